case_7_mul_share_arb: RTL
=========================

Name: case_7_mul_share_arb

Overview:
- Shares one 13-bit signed truncating multiplier among NUM_REQ requesters. Uses round-robin arbitration, a registered one-entry result slot and a saturating completed-operation counter.
- Sits between several HLS loop bodies that each need an occasional multiply and the single multiplier instance the schedule allows.
- Result is the low DW bits of the full signed product: the same arithmetic as the case_7 multiplier core with 13-bit operands and 13-bit result.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DW, 13, operand and result width (signed, two's complement).
- IDW, 2, requester-id width; must satisfy 2**IDW >= NUM_REQ.
- CNTW, 16, width of the saturating operation counter.

Ports:
- ap_clk  in  1  clock; all state changes on the rising edge.
- ap_rst  in  1  synchronous, active-high reset.
- req_vld  in  NUM_REQ  bit i: requester i presents operands.
- req_rdy  out  NUM_REQ  bit i: requester i's operands are accepted this cycle (one-hot or zero).
- req_a  in  NUM_REQ*DW  operand A; requester i occupies bits [i*DW +: DW].
- req_b  in  NUM_REQ*DW  operand B, same packing as req_a.
- rsp_vld  out  1  result slot holds a valid result.
- rsp_rdy  in  1  consumer takes the result.
- rsp_data  out  DW  product, low DW bits, signed.
- rsp_id  out  IDW  index of the requester that issued the result.
- op_cnt  out  CNTW  completed transfers on the response channel, saturating.
- busy  out  1  equals rsp_vld; registered.

Behaviour:
- Reset (ap_rst=1 at an edge):
  - rsp_vld=0, rsp_data=0, rsp_id=0, op_cnt=0, busy=0.
  - Round-robin pointer = 0.
  - req_rdy is combinational but forced to 0 while ap_rst=1.
  - Reset mid-operation discards any held result without a response.
- Slot free condition: slot_free = !rsp_vld | rsp_rdy.
- Arbitration (combinational):
  - If slot_free, grant the first i with req_vld[i]=1, searching from ptr, ptr+1, ... modulo NUM_REQ.
  - req_rdy = one-hot of the grant, or all zero when there is no grant.
  - If !slot_free, req_rdy=0.
- Accept (req_vld[g]&req_rdy[g] at an edge):
  - rsp_data <= low DW bits of signed(req_a[g]) * signed(req_b[g]).
  - rsp_id <= g; rsp_vld <= 1; ptr <= (g+1) mod NUM_REQ.
  - Latency is exactly 1 cycle from accept edge to rsp_vld=1.
- Drain: rsp_vld&rsp_rdy with no new grant sets rsp_vld <= 0; rsp_data and rsp_id hold their last values.
- Simultaneous drain and accept in the same cycle:
  - The slot reloads and rsp_vld stays 1.
  - Full throughput is 1 op/cycle.
- Backpressure (rsp_vld=1 and rsp_rdy=0):
  - rsp_data and rsp_id are held stable.
  - All req_rdy=0 and ptr is unchanged.
- No grant: ptr unchanged.
- Requester contract:
  - A requester may drop req_vld before it is granted.
  - Its operands must be stable only in the grant cycle.
- op_cnt:
  - Increments on every rsp_vld&rsp_rdy edge.
  - Saturates at 2**CNTW-1 with no wrap.
  - Cleared only by reset.
- Arithmetic:
  - The full 2*DW-bit signed product is truncated to [DW-1:0]; there is no saturation or rounding.
  - Overflow wraps modulo 2**DW.
- Fairness: with all requesters continuously valid and rsp_rdy=1, grants cycle 0,1,2,3,0,... Any waiting requester is granted within NUM_REQ accepted ops.
- State machine, two states:
  - EMPTY (rsp_vld=0) to FULL on accept.
  - FULL to EMPTY on drain with no accept.
  - FULL to FULL on drain with accept, or on stall.

Test Plan:
- Reset then single op: req_vld=0001, a=5, b=-3.
  - req_rdy=0001 that cycle.
  - Next cycle rsp_vld=1, rsp_data=-15 (0x1FF1), rsp_id=0, busy=1.
  - After rsp_rdy=1: op_cnt=1, rsp_vld=0.
- Truncation: a=100, b=100 (product 10000 = 0x2710).
  - rsp_data = 0x0710 = 1808.
  - a=-4096, b=-1: rsp_data = -4096 (0x1000), i.e. wrap.
- Round-robin: req_vld=1111 held, rsp_rdy=1 every cycle, distinct operands per requester.
  - rsp_id sequence 0,1,2,3,0,1 with one result per cycle.
  - Each rsp_data matches its requester's operands.
- Backpressure: fill the slot from requester 2, then hold rsp_rdy=0 for 5 cycles with req_vld=1011.
  - rsp_data and rsp_id stay constant; req_rdy=0000 throughout; op_cnt is unchanged.
  - On release, the next grant is requester 3 (ptr=3), then 0.
- Reset mid-operation: ap_rst=1 while rsp_vld=1 and rsp_rdy=0.
  - Next cycle rsp_vld=0, op_cnt=0, ptr=0.
  - With req_vld=1111 after reset, the first grant is requester 0.
- Counter saturation: use CNTW=4 and complete 20 transfers.
  - op_cnt reaches 15 and stays at 15.

Source files
------------

// File: rtl/case_7_mul_share_arb.sv
// One 13-bit signed truncating multiplier shared by NUM_REQ requesters.
// Round-robin grant into a one-entry registered result slot, plus a saturating op counter.
module case_7_mul_share_arb #(
  parameter int NUM_REQ = 4,
  parameter int DW      = 13,
  parameter int IDW     = 2,
  parameter int CNTW    = 16
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst,
  input  logic [NUM_REQ-1:0]     req_vld,
  output logic [NUM_REQ-1:0]     req_rdy,
  input  logic [NUM_REQ*DW-1:0]  req_a,
  input  logic [NUM_REQ*DW-1:0]  req_b,
  output logic                   rsp_vld,
  input  logic                   rsp_rdy,
  output logic [DW-1:0]          rsp_data,
  output logic [IDW-1:0]         rsp_id,
  output logic [CNTW-1:0]        op_cnt,
  output logic                   busy
);

  localparam int PW = 2 * DW;

  typedef enum logic {EMPTY, FULL} state_t;

  typedef struct packed {
    logic [DW-1:0]  data;
    logic [IDW-1:0] id;
  } rsp_t;

  state_t                    state_q, state_d;
  rsp_t                      rsp_q, rsp_d;
  logic [IDW-1:0]            ptr_q, ptr_d;
  logic [CNTW-1:0]           cnt_q, cnt_d;
  logic [NUM_REQ-1:0][DW-1:0] a_arr, b_arr;
  logic                      slot_free, gnt_vld, accept, drain;
  logic [IDW-1:0]            gnt_idx;
  logic [IDW:0]              idx;
  logic signed [DW-1:0]      op_a, op_b;

  assign a_arr     = req_a;
  assign b_arr     = req_b;
  assign rsp_vld   = (state_q == FULL);
  assign busy      = rsp_vld;
  assign rsp_data  = rsp_q.data;
  assign rsp_id    = rsp_q.id;
  assign op_cnt    = cnt_q;
  assign slot_free = !rsp_vld || rsp_rdy;
  assign drain     = rsp_vld && rsp_rdy;
  assign accept    = gnt_vld;

  // Search ptr, ptr+1, ... wrapping at NUM_REQ; first valid requester wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, ptr_q} + (IDW+1)'(k);
      if (idx >= (IDW+1)'(NUM_REQ)) idx = idx - (IDW+1)'(NUM_REQ);
      if (!gnt_vld && req_vld[idx[IDW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx[IDW-1:0];
      end
    end
    if (ap_rst || !slot_free) gnt_vld = 1'b0;
  end

  always_comb begin
    req_rdy = '0;
    if (gnt_vld) req_rdy[gnt_idx] = 1'b1;
  end

  assign op_a = a_arr[gnt_idx];
  assign op_b = b_arr[gnt_idx];

  always_comb begin
    state_d = state_q;
    rsp_d   = rsp_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (drain && !accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
    if (accept) begin
      // Full signed product, keep the low DW bits: wraps modulo 2**DW.
      rsp_d.data = DW'(PW'(op_a) * PW'(op_b));
      rsp_d.id   = gnt_idx;
      ptr_d      = (gnt_idx == IDW'(NUM_REQ-1)) ? '0 : gnt_idx + IDW'(1);
    end
    if (drain && cnt_q != '1) cnt_d = cnt_q + CNTW'(1);
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q <= EMPTY;
      rsp_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rsp_q   <= rsp_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
